// File: rtl/secuenciador_tubo_pkg.sv
// Shared definitions for the falling-note row sequencer and its renderer hookup.
package secuenciador_tubo_pkg;

  localparam int unsigned AnchoCarril  = 5;
  localparam int unsigned AnchoCoord   = 10;

  // Defaults shared with the renderer instantiation
  localparam int unsigned YStartDef    = 0;
  localparam int unsigned YHitDef      = 352;
  localparam int unsigned HitWinDef    = 32;
  localparam int unsigned GapFramesDef = 8;
  localparam int unsigned ScoreMaxDef  = 999;

  typedef logic [AnchoCarril-1:0] carril_t;
  typedef logic [AnchoCoord-1:0]  coord_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StFall,
    StWindow,
    StGap
  } estado_e;

  // Increment that sticks once the ceiling is reached
  function automatic coord_t suma_sat(input coord_t valor, input coord_t tope);
    return (valor >= tope) ? valor : valor + coord_t'(1);
  endfunction

endpackage

// File: rtl/secuenciador_tubo_contador_cuadros.sv
// Loadable down-counter of frame ticks; flags the tick that exhausts the count.
module contador_cuadros #(
  parameter int unsigned Ancho = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             carga_i,
  input  logic [Ancho-1:0] valor_i,
  input  logic             tick_i,
  output logic             fin_o
);

  logic [Ancho-1:0] cuenta_d, cuenta_q;

  // Load wins over a coincident tick; the count rests at zero
  always_comb begin
    cuenta_d = cuenta_q;
    if (carga_i) begin
      cuenta_d = valor_i;
    end else if (tick_i && (cuenta_q != '0)) begin
      cuenta_d = cuenta_q - Ancho'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  // Done is the tick that takes the count from one to zero
  always_comb begin
    fin_o = tick_i && !carga_i && (cuenta_q == Ancho'(1));
  end

endmodule

// File: rtl/secuenciador_tubo.sv
// Sequencer for the falling-note row renderer: fetches patterns, paces rows per
// frame, gates visibility and judges hits inside the hit window.
module secuenciador_tubo
  import secuenciador_tubo_pkg::*;
#(
  parameter int unsigned Y_START    = YStartDef,
  parameter int unsigned Y_HIT      = YHitDef,
  parameter int unsigned HIT_WIN    = HitWinDef,
  parameter int unsigned GAP_FRAMES = GapFramesDef,
  parameter int unsigned SCORE_MAX  = ScoreMaxDef
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   frame_tick,
  input  logic [AnchoCarril-1:0] nota_mask,
  input  logic                   nota_valid,
  output logic                   nota_ready,
  input  logic [AnchoCarril-1:0] golpe,
  output logic                   enable,
  output logic [AnchoCoord-1:0]  posicionY,
  output logic                   contar,
  output logic                   maquinaOut,
  output logic [AnchoCarril-1:0] mascara,
  output logic [AnchoCoord-1:0]  pos_actual,
  output logic                   acierto,
  output logic                   fallo,
  output logic [AnchoCoord-1:0]  puntaje,
  output logic                   activo
);

  // Elaboration-time legality of the geometry
  if (Y_HIT + HIT_WIN > 1023) begin : g_err_ventana
    $error("secuenciador_tubo: Y_HIT+HIT_WIN exceeds 1023");
  end
  if (Y_START >= Y_HIT) begin : g_err_inicio
    $error("secuenciador_tubo: Y_START must be below Y_HIT");
  end
  if ((GAP_FRAMES < 1) || (GAP_FRAMES > 255)) begin : g_err_gap
    $error("secuenciador_tubo: GAP_FRAMES must be within 1..255");
  end
  if (SCORE_MAX > 1023) begin : g_err_puntaje
    $error("secuenciador_tubo: SCORE_MAX does not fit in 10 bits");
  end

  localparam coord_t     YStartC  = coord_t'(Y_START);
  localparam coord_t     YHitC    = coord_t'(Y_HIT);
  localparam coord_t     YFinC    = coord_t'(Y_HIT + HIT_WIN);
  localparam coord_t     ScoreC   = coord_t'(SCORE_MAX);
  localparam logic [7:0] GapC     = 8'(GAP_FRAMES);

  estado_e state_d, state_q;
  coord_t  pos_d, pos_q;
  coord_t  puntaje_d, puntaje_q;
  carril_t mascara_d, mascara_q;
  carril_t golpe_q;
  logic    contar_d, contar_q;
  logic    acierto_d, acierto_q;
  logic    fallo_d, fallo_q;

  carril_t flanco;
  coord_t  pos_inc;
  logic    gap_carga;
  logic    gap_tick;
  logic    gap_fin;

  assign flanco   = golpe & ~golpe_q;
  assign pos_inc  = pos_q + coord_t'(1);
  assign gap_tick = frame_tick && (state_q == StGap);

  contador_cuadros #(
    .Ancho (8)
  ) u_contador_gap (
    .clk_i   (clk),
    .rst_ni  (reset),
    .carga_i (gap_carga),
    .valor_i (GapC),
    .tick_i  (gap_tick),
    .fin_o   (gap_fin)
  );

  // Next-state, row tracking and judgement; stop overrides everything
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    puntaje_d = puntaje_q;
    mascara_d = mascara_q;
    contar_d  = 1'b0;
    acierto_d = 1'b0;
    fallo_d   = 1'b0;
    gap_carga = 1'b0;

    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            puntaje_d = '0;
            state_d   = StFetch;
          end
        end
        StFetch: begin
          if (nota_valid) begin
            if (nota_mask != '0) begin
              mascara_d = nota_mask;
              state_d   = StLoad;
            end else begin
              // Rest pattern: no row, just wait out the gap
              gap_carga = 1'b1;
              state_d   = StGap;
            end
          end
        end
        StLoad: begin
          pos_d   = YStartC;
          state_d = StFall;
        end
        StFall: begin
          if (frame_tick) begin
            contar_d = 1'b1;
            pos_d    = pos_inc;
            if (pos_inc == YHitC) begin
              state_d = StWindow;
            end
          end
        end
        StWindow: begin
          if (frame_tick) begin
            contar_d = 1'b1;
            pos_d    = pos_inc;
          end
          // A press sampled with the expiry tick still counts
          if (flanco != '0) begin
            if (flanco == mascara_q) begin
              acierto_d = 1'b1;
              puntaje_d = suma_sat(puntaje_q, ScoreC);
            end else begin
              fallo_d = 1'b1;
            end
            gap_carga = 1'b1;
            state_d   = StGap;
          end else if (frame_tick && (pos_inc == YFinC)) begin
            fallo_d   = 1'b1;
            gap_carga = 1'b1;
            state_d   = StGap;
          end
        end
        StGap: begin
          if (gap_fin) begin
            state_d = StFetch;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      pos_q     <= '0;
      puntaje_q <= '0;
      mascara_q <= '0;
      golpe_q   <= '0;
      contar_q  <= 1'b0;
      acierto_q <= 1'b0;
      fallo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      puntaje_q <= puntaje_d;
      mascara_q <= mascara_d;
      golpe_q   <= golpe;
      contar_q  <= contar_d;
      acierto_q <= acierto_d;
      fallo_q   <= fallo_d;
    end
  end

  // Output decode from registered state
  always_comb begin
    posicionY  = YStartC;
    enable     = (state_q == StLoad);
    nota_ready = (state_q == StFetch);
    maquinaOut = (state_q == StFall) || (state_q == StWindow);
    activo     = (state_q != StIdle);
    contar     = contar_q;
    acierto    = acierto_q;
    fallo      = fallo_q;
    pos_actual = pos_q;
    mascara    = mascara_q;
    puntaje    = puntaje_q;
  end

endmodule

// File: tb/tb_secuenciador_tubo.sv
// Directed bench for secuenciador_tubo: vector table plus multi-cycle sequences.
module tb_secuenciador_tubo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start, stop, frame_tick, nota_valid;
  logic [4:0] nota_mask, golpe;
  logic       nota_ready, enable, contar, maquinaOut, acierto, fallo, activo;
  logic [9:0] posicionY, pos_actual, puntaje;
  logic [4:0] mascara;

  // Second instance with tiny geometry for score saturation and short gaps
  logic       start2, stop2, tick2, valid2;
  logic [4:0] mask2, golpe2;
  logic       ready2, en2, contar2, maq2, ac2, fa2, act2;
  logic [9:0] posy2, pos2, punt2;
  logic [4:0] masc2;

  secuenciador_tubo dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .frame_tick (frame_tick),
    .nota_mask  (nota_mask),
    .nota_valid (nota_valid),
    .nota_ready (nota_ready),
    .golpe      (golpe),
    .enable     (enable),
    .posicionY  (posicionY),
    .contar     (contar),
    .maquinaOut (maquinaOut),
    .mascara    (mascara),
    .pos_actual (pos_actual),
    .acierto    (acierto),
    .fallo      (fallo),
    .puntaje    (puntaje),
    .activo     (activo)
  );

  secuenciador_tubo #(
    .Y_START    (1),
    .Y_HIT      (4),
    .HIT_WIN    (4),
    .GAP_FRAMES (1),
    .SCORE_MAX  (3)
  ) dut2 (
    .clk        (clk),
    .reset      (reset),
    .start      (start2),
    .stop       (stop2),
    .frame_tick (tick2),
    .nota_mask  (mask2),
    .nota_valid (valid2),
    .nota_ready (ready2),
    .golpe      (golpe2),
    .enable     (en2),
    .posicionY  (posy2),
    .contar     (contar2),
    .maquinaOut (maq2),
    .mascara    (masc2),
    .pos_actual (pos2),
    .acierto    (ac2),
    .fallo      (fa2),
    .puntaje    (punt2),
    .activo     (act2)
  );

  int total = 0;
  int bad = 0;
  int n_acierto = 0;
  int n_fallo = 0;
  int n_contar = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (acierto) n_acierto++;
      if (fallo) n_fallo++;
      if (contar) n_contar++;
    end
  end

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       tick;
    logic       valid;
    logic [4:0] mask;
    logic [4:0] golpe;
    logic [6:0] exp_bits;  // {enable, ready, maquina, contar, acierto, fallo, activo}
    logic [9:0] exp_pos;
  } vec_t;

  vec_t tabla[23];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nombre, act, req);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  // From FETCH: hand over a pattern, pass LOAD, land in FALL
  task automatic load_row(input logic [4:0] m);
    nota_valid = 1'b1;
    nota_mask  = m;
    step();
    chk("load_enable", 32'(enable), 32'd1);
    nota_valid = 1'b0;
    step();
    chk("load_fall_visible", 32'(maquinaOut), 32'd1);
  endtask

  initial begin
    int f0, a0, c0;
    logic [6:0] act_bits;

    //                 st    sp    tk    va    mask      golpe     en rd mq ct ac fa act   pos
    tabla[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'b00101, 5'b00000, 7'b0100001, 10'd0};
    tabla[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00101, 5'b00000, 7'b1000001, 10'd0};
    tabla[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 7'b0010001, 10'd0};
    tabla[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 7'b0011001, 10'd1};
    tabla[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 7'b0010001, 10'd1};
    tabla[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00101, 7'b0010001, 10'd1};
    tabla[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 7'b0010001, 10'd1};
    tabla[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 7'b0011001, 10'd2};
    tabla[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 5'b00000, 7'b0000000, 10'd2};
    tabla[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 7'b0000000, 10'd2};
    tabla[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 7'b0100001, 10'd2};
    tabla[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 7'b0100001, 10'd2};
    tabla[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000, 7'b0000001, 10'd2};
    tabla[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 5'b00000, 7'b0000001, 10'd2};
    for (int i = 14; i < 21; i++) begin
      tabla[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 7'b0000001, 10'd2};
    end
    tabla[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 7'b0100001, 10'd2};
    tabla[22] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'b00000, 5'b00000, 7'b0000000, 10'd2};

    reset = 1'b0;
    {start, stop, frame_tick, nota_valid, nota_mask, golpe} = '0;
    {start2, stop2, tick2, valid2, mask2, golpe2} = '0;
    step();
    step();

    // Reset state
    chk("rst_activo", 32'(activo), 32'd0);
    chk("rst_ready", 32'(nota_ready), 32'd0);
    chk("rst_posicionY", 32'(posicionY), 32'd0);
    chk("rst_pos", 32'(pos_actual), 32'd0);
    chk("rst_puntaje", 32'(puntaje), 32'd0);
    chk("rst_mascara", 32'(mascara), 32'd0);
    chk("rst_posicionY2", 32'(posy2), 32'd1);
    reset = 1'b1;
    step();

    // Table: start latency, dropped ticks, early edge, stop priority, rest pattern
    for (int i = 0; i < 23; i++) begin
      start      = tabla[i].start;
      stop       = tabla[i].stop;
      frame_tick = tabla[i].tick;
      nota_valid = tabla[i].valid;
      nota_mask  = tabla[i].mask;
      golpe      = tabla[i].golpe;
      step();
      act_bits = {enable, nota_ready, maquinaOut, contar, acierto, fallo, activo};
      chk($sformatf("vec%0d_bits", i), 32'(act_bits), 32'(tabla[i].exp_bits));
      chk($sformatf("vec%0d_pos", i), 32'(pos_actual), 32'(tabla[i].exp_pos));
    end
    {start, stop, frame_tick, nota_valid, nota_mask, golpe} = '0;
    step();

    // Happy path
    start      = 1'b1;
    nota_valid = 1'b1;
    nota_mask  = 5'b00101;
    step();
    start = 1'b0;
    chk("hp_fetch_ready", 32'(nota_ready), 32'd1);
    step();
    chk("hp_enable", 32'(enable), 32'd1);
    chk("hp_mascara", 32'(mascara), 32'h05);
    nota_valid = 1'b0;
    step();
    chk("hp_pos_start", 32'(pos_actual), 32'd0);
    tick_n(351);
    chk("hp_pos351", 32'(pos_actual), 32'd351);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("hp_contar", 32'(contar), 32'd1);
    chk("hp_pos352", 32'(pos_actual), 32'd352);
    step();
    golpe = 5'b00101;
    step();
    chk("hp_acierto", 32'(acierto), 32'd1);
    chk("hp_no_fallo", 32'(fallo), 32'd0);
    chk("hp_puntaje", 32'(puntaje), 32'd1);
    chk("hp_invisible", 32'(maquinaOut), 32'd0);
    golpe = 5'b00000;
    step();
    chk("hp_acierto_1cyc", 32'(acierto), 32'd0);
    tick_n(7);
    chk("hp_gap7_ready", 32'(nota_ready), 32'd0);
    tick_n(1);
    chk("hp_gap8_ready", 32'(nota_ready), 32'd1);

    // Miss by timeout
    f0 = n_fallo;
    load_row(5'b00101);
    tick_n(383);
    chk("to_pos383", 32'(pos_actual), 32'd383);
    chk("to_no_early_fallo", 32'(n_fallo), 32'(f0));
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    chk("to_fallo", 32'(fallo), 32'd1);
    chk("to_no_acierto", 32'(acierto), 32'd0);
    chk("to_puntaje", 32'(puntaje), 32'd1);
    chk("to_invisible", 32'(maquinaOut), 32'd0);
    step();
    tick_n(8);
    chk("to_fetch", 32'(nota_ready), 32'd1);
    chk("to_one_fallo", 32'(n_fallo), 32'(f0 + 1));

    // Wrong lanes, with an ignored edge before the window
    f0 = n_fallo;
    a0 = n_acierto;
    load_row(5'b00101);
    tick_n(100);
    golpe = 5'b00101;
    step();
    golpe = 5'b00000;
    step();
    chk("wl_early_no_fallo", 32'(n_fallo), 32'(f0));
    chk("wl_early_no_acierto", 32'(n_acierto), 32'(a0));
    chk("wl_still_visible", 32'(maquinaOut), 32'd1);
    tick_n(252);
    chk("wl_pos352", 32'(pos_actual), 32'd352);
    golpe = 5'b00100;
    step();
    chk("wl_fallo", 32'(fallo), 32'd1);
    chk("wl_no_acierto", 32'(acierto), 32'd0);
    golpe = 5'b00000;
    step();
    tick_n(8);
    chk("wl_puntaje", 32'(puntaje), 32'd1);
    chk("wl_fetch", 32'(nota_ready), 32'd1);

    // Hit edge together with the expiry tick resolves as a hit
    f0 = n_fallo;
    load_row(5'b00101);
    tick_n(383);
    golpe      = 5'b00101;
    frame_tick = 1'b1;
    step();
    golpe      = 5'b00000;
    frame_tick = 1'b0;
    chk("bd_acierto", 32'(acierto), 32'd1);
    chk("bd_no_fallo", 32'(fallo), 32'd0);
    chk("bd_puntaje", 32'(puntaje), 32'd2);
    step();
    chk("bd_no_late_fallo", 32'(n_fallo), 32'(f0));
    tick_n(8);

    // Stop mid-FALL
    load_row(5'b10000);
    tick_n(10);
    c0   = n_contar;
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ab_activo", 32'(activo), 32'd0);
    chk("ab_invisible", 32'(maquinaOut), 32'd0);
    chk("ab_puntaje_held", 32'(puntaje), 32'd2);
    tick_n(3);
    chk("ab_no_contar", 32'(n_contar), 32'(c0));

    // Asynchronous reset mid-WINDOW
    start      = 1'b1;
    nota_valid = 1'b1;
    nota_mask  = 5'b00011;
    step();
    start = 1'b0;
    chk("ar_start_clears", 32'(puntaje), 32'd0);
    step();
    nota_valid = 1'b0;
    step();
    tick_n(360);
    chk("ar_in_window", 32'(maquinaOut), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("ar_invisible", 32'(maquinaOut), 32'd0);
    chk("ar_activo", 32'(activo), 32'd0);
    chk("ar_pos", 32'(pos_actual), 32'd0);
    chk("ar_mascara", 32'(mascara), 32'd0);
    chk("ar_posicionY", 32'(posicionY), 32'd0);
    chk("ar_strobes", 32'({enable, nota_ready, contar, acierto, fallo}), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Score saturation on the small instance
    start2 = 1'b1;
    valid2 = 1'b1;
    mask2  = 5'b00011;
    step();
    start2 = 1'b0;
    for (int r = 0; r < 5; r++) begin
      step();
      chk($sformatf("sat%0d_enable", r), 32'(en2), 32'd1);
      valid2 = 1'b0;
      step();
      chk($sformatf("sat%0d_pos_start", r), 32'(pos2), 32'd1);
      for (int k = 0; k < 3; k++) begin
        tick2 = 1'b1;
        step();
        tick2 = 1'b0;
        step();
      end
      golpe2 = 5'b00011;
      step();
      chk($sformatf("sat%0d_acierto", r), 32'(ac2), 32'd1);
      chk($sformatf("sat%0d_puntaje", r), 32'(punt2), 32'((r + 1 > 3) ? 3 : r + 1));
      golpe2 = 5'b00000;
      step();
      tick2 = 1'b1;
      step();
      tick2 = 1'b0;
      chk($sformatf("sat%0d_fetch", r), 32'(ready2), 32'd1);
      valid2 = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secuenciador_tubo.md
# secuenciador_tubo

Controller that sequences the falling-note row renderer: fetches one 5-lane note pattern at a time from the song source, loads the row's start Y, and issues one advance pulse per video frame. It also gates row visibility and judges player hits inside a fixed hit window. It sits between the song pattern source and the row renderer's `enable` / `posicionY` / `contar` / `maquinaOut` inputs, and feeds hit/miss pulses and score to the HUD.

## Interface

Parameters:
- `Y_START`, default 0: Y loaded into the renderer for a new row.
- `Y_HIT`, default 352: first Y of the hit window.
- `HIT_WIN`, default 32: window length in pixels; the window is `Y_HIT ≤ pos < Y_HIT+HIT_WIN`.
- `GAP_FRAMES`, default 8: blank frames between rows, 1..255.
- `SCORE_MAX`, default 999: score saturation value.

Ports:
- `clk` in, 1: system/pixel clock.
- `reset` in, 1: asynchronous, active-low reset.
- `start` in, 1: 1-cycle pulse; begins the song.
- `stop` in, 1: 1-cycle pulse; aborts to IDLE.
- `frame_tick` in, 1: 1-cycle pulse once per frame, during vertical blank.
- `nota_mask` in, 5: lane pattern, bit i = lane i+1.
- `nota_valid` in, 1: pattern available.
- `nota_ready` out, 1: pattern accepted when `nota_valid && nota_ready`.
- `golpe` in, 5: debounced player button levels.
- `enable` out, 1: 1-cycle load strobe to the renderer.
- `posicionY` out, 10: load value; constant `Y_START`.
- `contar` out, 1: 1-cycle advance strobe to the renderer.
- `maquinaOut` out, 1: row visible.
- `mascara` out, 5: latched current pattern.
- `pos_actual` out, 10: tracked row Y, mirrors the renderer.
- `acierto` out, 1: 1-cycle hit pulse.
- `fallo` out, 1: 1-cycle miss pulse.
- `puntaje` out, 10: hit count, saturating.
- `activo` out, 1: high whenever the state is not IDLE.

## Operation

FSM states: IDLE, FETCH, LOAD, FALL, WINDOW, GAP.

- **IDLE:** all strobes 0. `start` → FETCH; `start` also clears `puntaje`.
- **FETCH:** `nota_ready`=1.
  - On handshake with `nota_mask`≠0: latch `mascara` → LOAD.
  - On handshake with `nota_mask`=0 (rest): → GAP.
  - No valid: stay in FETCH indefinitely.
- **LOAD:** `enable`=1 for exactly 1 cycle; `pos_actual`←`Y_START`; `maquinaOut`←1 → FALL.
- **FALL:** on each `frame_tick`, `contar`=1 next cycle and `pos_actual`+1. When the incremented value equals `Y_HIT` → WINDOW.
- **WINDOW:** `contar` continues per frame.
  - On a `golpe` rising edge set (edges of all 5 lanes taken in one cycle) exactly equal to `mascara`: `acierto` pulse, `puntaje`+1 (saturate at `SCORE_MAX`) → GAP.
  - A nonzero edge set that is not equal to `mascara`: `fallo` pulse → GAP.
  - When `pos_actual` would reach `Y_HIT+HIT_WIN`: `fallo` pulse → GAP.
- **GAP:** `maquinaOut`=0; count `GAP_FRAMES` frame ticks, then → FETCH.
- Edges of `golpe` outside WINDOW are ignored. Edge detection uses a registered copy of `golpe`, cleared on reset.
- `pos_actual` is 10-bit unsigned. Parameter legality, checked at elaboration: `Y_HIT+HIT_WIN` ≤ 1023 and `Y_START` < `Y_HIT`.

## Timing

- **Reset:** state IDLE. All outputs 0 except `posicionY`=`Y_START`. `pos_actual`, `mascara`, `puntaje` = 0; GAP counter = 0.
- **`start` to first `enable`:** 2 cycles when `nota_valid` is already high (FETCH, then handshake edge, then LOAD).
- **`frame_tick` to `contar`:** 1 cycle. `pos_actual` updates on the same edge that asserts `contar`. A `frame_tick` arriving in LOAD or FETCH is dropped.
- **`acierto`/`fallo`:** asserted the cycle after the deciding event; never both in the same cycle. The hit counts as a hit only if its edge arrives no later than the cycle in which the window-expiry tick is sampled; that is, on the last window pixel a hit and expiry in the same cycle resolve as `acierto`.
- **`stop`:** highest priority, from any state → IDLE next cycle. `maquinaOut` 0 and strobes 0; `puntaje` is held.
- **`start` while not IDLE:** ignored.
- **Asynchronous reset mid-row:** all outputs drop immediately. The renderer is reloaded on the next LOAD.

## Structure

- Shared package holds:
  - the state enum;
  - lane-width constant 5 and coordinate width 10;
  - defaults for `Y_START`, `Y_HIT`, `HIT_WIN`, used by both this block and the renderer instantiation.
- One sub-module, `contador_cuadros`: loadable down-counter of frame ticks with a `done` flag, used for GAP.
- Edge detection and the FSM stay in the top module.

## Test plan

- **Happy path:** `nota_mask`=5'b00101 valid, `start` → `enable` 2 cycles later, then 352 `frame_tick`s → WINDOW. Then `golpe`=5'b00101 edge → `acierto`, `puntaje`=1, `maquinaOut`=0, and after 8 ticks `nota_ready`=1.
- **Miss by timeout:** same pattern, no `golpe` → `fallo` exactly when `pos_actual` would reach 384; `puntaje` unchanged.
- **Wrong lanes:** `golpe` edge 5'b00100 in window for mask 5'b00101 → `fallo`; an edge before `pos_actual`=352 → no pulse.
- **Rest pattern:** `nota_mask`=0 → no `enable`, `maquinaOut` stays 0, then FETCH after 8 ticks.
- **Boundaries:** hit edge coinciding with the expiry tick → `acierto` only. `puntaje` at 999 plus a hit → stays 999.
- **Abort and reset:** `stop` mid-FALL → IDLE, `maquinaOut` 0, no `contar` on later ticks. `reset` low mid-WINDOW → all outputs at reset values asynchronously.
